hand_mem_allocator: RTL and testbench
=====================================

Name: hand_mem_allocator

Overview:
- Responder side of the hand-allocation handshake. A player raises `enable`; the block returns a block-aligned 10-bit base address and asserts `adr_found`.
- Manages the shared card memory as NUM_BLOCKS fixed-size blocks, using a circular free-list FIFO of block indices.
- Also accepts block frees, so a finished hand's storage is recycled for the next deal.

Parameters:
- ADDR_W, 10, width of card-memory addresses.
- BLOCK_SHIFT, 4, log2 of words per hand block (16 words/block).
- NUM_BLOCKS, 64, number of allocatable blocks; NUM_BLOCKS << BLOCK_SHIFT must be <= 2**ADDR_W.
- CNT_W, 7, width of free_count; must hold the value NUM_BLOCKS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  allocation request, level-sensitive.
- adr_found  out  1  grant valid; address is meaningful while high.
- address  out  ADDR_W  granted base address = block_index << BLOCK_SHIFT.
- free_en  in  1  single-cycle strobe: return a block.
- free_addr  in  ADDR_W  base of block being freed; low BLOCK_SHIFT bits ignored.
- ready  out  1  high once the free list is initialised.
- free_count  out  CNT_W  number of blocks currently free.
- err_double_free  out  1  one-cycle error pulse (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clock and resetn.
- Reset values: adr_found=0, address=0, ready=0, free_count=0, err_double_free=0, FIFO rd_ptr=wr_ptr=0, state=INIT.
- INIT: writes index i into FIFO slot i for i = 0..NUM_BLOCKS-1, one per cycle; free_count increments each cycle.
  - After NUM_BLOCKS cycles: ready=1, free_count=NUM_BLOCKS, go to IDLE.
  - enable and free_en are ignored during INIT.
- IDLE:
  - enable=1 and free_count>0: pop the head index and go to GRANT. On the next edge, address = index << BLOCK_SHIFT and adr_found=1. Latency: 1 cycle from enable sampled high to adr_found high.
  - enable=1 and free_count==0: go to WAIT.
- WAIT (out of memory): adr_found stays 0. The first free_en accepted is bypassed straight to the grant (the index is not written to the FIFO) and the state goes to GRANT; free_count stays 0.
- GRANT: adr_found and address are held stable until enable has been observed low and then rises again.
  - The held grant is released when enable is next sampled high; that request is then serviced as in IDLE.
  - While enable stays low, the block remains in GRANT indefinitely. The player deasserts enable combinationally on adr_found and never re-raises it, so this is the expected steady state.
- Frees: free_en in IDLE/GRANT pushes free_addr >> BLOCK_SHIFT and increments free_count.
  - A push when free_count==NUM_BLOCKS is dropped; free_count saturates.
  - Simultaneous pop and push in the same cycle: both happen and free_count is unchanged. When free_count==0, the push bypasses to the pop.
- Pointers: log2(NUM_BLOCKS) bits each, wrap modulo NUM_BLOCKS.
- Reset mid-operation: any held grant is lost and INIT reruns, so every block becomes free again.

Optional Feature:
- Macro HAND_ALLOC_FREE_CHECK_EN.
- Defined: an NUM_BLOCKS-bit allocated bitmap is kept. The bit is set on grant and cleared on a valid free. A free of a block whose bit is 0 is ignored: no push, free_count unchanged, err_double_free pulses high for 1 cycle. The bitmap is cleared on reset.
- Undefined: no bitmap; every free is accepted, subject only to the full-saturation rule; err_double_free is tied 0.

Test Plan:
- Release resetn, hold enable=0 -> ready rises exactly 64 cycles later, free_count=64.
- After ready, raise enable and drop it when adr_found=1 (player behaviour) -> adr_found 1 cycle later, address=0x000, held; free_count=63.
- Issue 64 successive requests (drop enable, raise again) -> addresses 0x000, 0x010 … 0x3F0 in order. A 65th request -> WAIT, adr_found=0, free_count=0. Then free_en with free_addr=0x123 -> next grant address=0x120.
- Same cycle enable request + free_en(0x050) with free_count=10 -> grant popped, 0x050 pushed, free_count stays 10.
- With HAND_ALLOC_FREE_CHECK_EN: free 0x020 twice -> first accepted (count+1), second raises err_double_free for 1 cycle and count is unchanged. Without the macro: both are pushed.
- Assert resetn=0 while in GRANT -> adr_found=0, address=0 immediately (async). INIT reruns and free_count returns to 64.

Source files
------------

// File: rtl/hand_mem_allocator_if.sv
// Hand-allocation bus between a player (master) and the block allocator (slave).
// Carries the allocation handshake, the free strobe and the allocator status.
interface hand_mem_allocator_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 7
);
    logic              enable;
    logic              adr_found;
    logic [ADDR_W-1:0] address;
    logic              free_en;
    logic [ADDR_W-1:0] free_addr;
    logic              ready;
    logic [CNT_W-1:0]  free_count;
    logic              err_double_free;

    modport master (
        output enable, free_en, free_addr,
        input  adr_found, address, ready, free_count, err_double_free
    );

    modport slave (
        input  enable, free_en, free_addr,
        output adr_found, address, ready, free_count, err_double_free
    );
endinterface

// File: rtl/hand_mem_allocator.sv
// Fixed-size block allocator for the shared card memory.
// The free list is a circular FIFO of block indices. It is filled with
// 0..NUM_BLOCKS-1 after reset, popped on grants and pushed on frees.
// Optional macro HAND_ALLOC_FREE_CHECK_EN adds an allocated-block bitmap.
// With the bitmap, frees of blocks that are not allocated are rejected
// and flagged on err_double_free.
module hand_mem_allocator #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_SHIFT = 4,
    parameter int NUM_BLOCKS  = 64,
    parameter int CNT_W       = 7
) (
    input logic                clock,
    input logic                resetn,
    hand_mem_allocator_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_BLOCKS);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_GRANT} state_t;

    state_t            r_state, w_state_nxt;
    logic [PTR_W-1:0]  r_fifo [NUM_BLOCKS];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_adr_found, r_ready, r_err, r_seen_low;
    logic [ADDR_W-1:0] r_address;

    logic [PTR_W-1:0]  w_free_idx, w_grant_idx, w_rd_inc, w_wr_inc;
    logic              w_free_ok, w_dbl, w_req, w_empty, w_full;
    logic              w_bypass, w_pop, w_push, w_grant, w_init_last;

    assign w_free_idx  = bus.free_addr[BLOCK_SHIFT +: PTR_W];
    assign w_rd_inc    = (r_rd_ptr == PTR_W'(NUM_BLOCKS - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_inc    = (r_wr_ptr == PTR_W'(NUM_BLOCKS - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(NUM_BLOCKS));
    assign w_init_last = (r_wr_ptr == PTR_W'(NUM_BLOCKS - 1));

`ifdef HAND_ALLOC_FREE_CHECK_EN
    logic [NUM_BLOCKS-1:0] r_alloc;

    assign w_free_ok = bus.free_en && (r_state != S_INIT) && r_alloc[w_free_idx];
    assign w_dbl     = bus.free_en && (r_state != S_INIT) && !r_alloc[w_free_idx];

    // Track which blocks are out; a grant after a free wins on the same index (bypass)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_alloc <= '0;
        end else begin
            if (w_free_ok) r_alloc[w_free_idx]  <= 1'b0;
            if (w_grant)   r_alloc[w_grant_idx] <= 1'b1;
        end
    end
`else
    assign w_free_ok = bus.free_en && (r_state != S_INIT);
    assign w_dbl     = 1'b0;
`endif

    // Request decode, FIFO control and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_bypass    = 1'b0;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_grant     = 1'b0;
        w_grant_idx = r_fifo[r_rd_ptr];
        if (r_state != S_INIT) begin
            // A held grant is only released by a fresh rising request
            w_req    = bus.enable && ((r_state == S_IDLE) || (r_state == S_GRANT && r_seen_low));
            // Empty list: a returning block goes straight to the waiting requester
            w_bypass = w_free_ok && w_empty && (w_req || r_state == S_WAIT);
            w_pop    = w_req && !w_empty;
            w_push   = w_free_ok && !w_bypass && !w_full;
            w_grant  = w_pop || w_bypass;
            if (w_bypass) w_grant_idx = w_free_idx;
        end
        case (r_state)
            S_INIT:  if (w_init_last) w_state_nxt = S_IDLE;
            default: begin
                if (w_grant)    w_state_nxt = S_GRANT;
                else if (w_req) w_state_nxt = S_WAIT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_INIT;
        else         r_state <= w_state_nxt;
    end

    // Pointers, free count and grant outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_adr_found <= 1'b0;
            r_address   <= '0;
            r_seen_low  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_dbl;
            if (r_state == S_INIT) begin
                r_wr_ptr <= w_wr_inc;
                r_count  <= r_count + 1'b1;
                if (w_init_last) r_ready <= 1'b1;
            end else begin
                if (w_pop)  r_rd_ptr <= w_rd_inc;
                if (w_push) r_wr_ptr <= w_wr_inc;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            end
            if (w_grant) begin
                r_adr_found <= 1'b1;
                r_address   <= ADDR_W'(w_grant_idx) << BLOCK_SHIFT;
                r_seen_low  <= 1'b0;
            end else if (w_req) begin
                r_adr_found <= 1'b0;
            end else if (r_state == S_GRANT && !bus.enable) begin
                r_seen_low  <= 1'b1;
            end
        end
    end

    // Free-list storage; rebuilt from scratch by INIT so it needs no reset
    always_ff @(posedge clock) begin
        if (r_state == S_INIT) r_fifo[r_wr_ptr] <= r_wr_ptr;
        else if (w_push)       r_fifo[r_wr_ptr] <= w_free_idx;
    end

    assign bus.adr_found       = r_adr_found;
    assign bus.address         = r_address;
    assign bus.ready           = r_ready;
    assign bus.free_count      = r_count;
    assign bus.err_double_free = r_err;
endmodule

// File: tb/tb_hand_mem_allocator.sv
// Testbench for hand_mem_allocator: directed scenarios followed by random
// traffic. A queue-based model of the free list predicts every output.
module tb_hand_mem_allocator;
`ifdef HAND_ALLOC_FREE_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    localparam int NB = 64;
    localparam int M_IDLE = 0, M_WAIT = 1, M_GRANT = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    hand_mem_allocator_if #(.ADDR_W(10), .CNT_W(7)) bus ();

    hand_mem_allocator #(.ADDR_W(10), .BLOCK_SHIFT(4), .NUM_BLOCKS(NB), .CNT_W(7)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: list of free block indices plus the player-visible grant state
    int q[$];
    bit m_alloc [NB];
    int m_mode;
    bit m_seen_low, m_found, m_err;
    int m_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < NB; i++) begin
            q.push_back(i);
            m_alloc[i] = 1'b0;
        end
        m_mode = M_IDLE; m_seen_low = 0; m_found = 0; m_err = 0; m_addr = 0;
    endtask

    task automatic m_step(input bit en, input bit fe, input int fa);
        int  fidx, got;
        bit  valid, req, was_full;
        fidx     = (fa >> 4) % NB;
        valid    = fe && (!CHECK || m_alloc[fidx]);
        m_err    = fe && CHECK && !m_alloc[fidx];
        req      = en && (m_mode == M_IDLE || (m_mode == M_GRANT && m_seen_low));
        was_full = (q.size() == NB);
        got      = -1;
        if (m_mode == M_GRANT && !en) m_seen_low = 1;
        if (valid && q.size() == 0 && (req || m_mode == M_WAIT)) begin
            got = fidx;
        end else begin
            if (req && q.size() > 0) got = q.pop_front();
            if (valid && !was_full) q.push_back(fidx);
        end
        if (valid)   m_alloc[fidx] = 1'b0;
        if (got >= 0) begin
            m_alloc[got] = 1'b1;
            m_mode = M_GRANT; m_found = 1; m_addr = got << 4; m_seen_low = 0;
        end else if (req) begin
            m_mode = M_WAIT; m_found = 0;
        end
    endtask

    // Apply one cycle of inputs (called at a falling edge), then compare after the edge
    task automatic step(input bit en, input bit fe, input int fa);
        bus.enable    = en;
        bus.free_en   = fe;
        bus.free_addr = 10'(fa);
        m_step(en, fe, fa);
        @(negedge clock);
        chk("adr_found", 32'(bus.adr_found), 32'(m_found));
        if (m_found) chk("address", 32'(bus.address), 32'(m_addr));
        chk("free_count", 32'(bus.free_count), 32'(q.size()));
        chk("err_double_free", 32'(bus.err_double_free), 32'(m_err));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'd64);
        chk({tag, "_count"}, 32'(bus.free_count), 32'd64);
        m_reset();
    endtask

    initial begin
        bus.enable = 1'b0; bus.free_en = 1'b0; bus.free_addr = '0;
        repeat (2) @(negedge clock);
        chk("rst_found", 32'(bus.adr_found), 0);
        chk("rst_addr", 32'(bus.address), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_count", 32'(bus.free_count), 0);
        chk("rst_err", 32'(bus.err_double_free), 0);
        resetn = 1'b1;
        wait_ready("init");

        // First grant, held while the player keeps enable low
        step(1, 0, 0);
        chk("first_addr", 32'(bus.address), 32'h000);
        chk("first_count", 32'(bus.free_count), 63);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("held_found", 32'(bus.adr_found), 1);
        chk("held_addr", 32'(bus.address), 32'h000);

        // Drain the whole list in index order
        for (int i = 1; i < NB; i++) begin
            step(1, 0, 0);
            chk("seq_addr", 32'(bus.address), 32'(i << 4));
            step(0, 0, 0);
        end
        step(1, 0, 0);
        chk("oom_found", 32'(bus.adr_found), 0);
        chk("oom_count", 32'(bus.free_count), 0);
        step(1, 1, 32'h123);
        chk("bypass_found", 32'(bus.adr_found), 1);
        chk("bypass_addr", 32'(bus.address), 32'h120);
        chk("bypass_count", 32'(bus.free_count), 0);
        step(0, 0, 0);

        // Build up ten free blocks, then request and free in the same cycle
        for (int i = 10; i < 20; i++) step(0, 1, i << 4);
        chk("ten_count", 32'(bus.free_count), 10);
        step(1, 1, 32'h050);
        chk("simul_addr", 32'(bus.address), 32'h0A0);
        chk("simul_count", 32'(bus.free_count), 10);
        step(0, 0, 0);

        // Free the same block twice
        step(0, 1, 32'h020);
        chk("free1_count", 32'(bus.free_count), 11);
        step(0, 1, 32'h020);
        chk("free2_err", 32'(bus.err_double_free), CHECK ? 1 : 0);
        chk("free2_count", 32'(bus.free_count), CHECK ? 11 : 12);
        step(0, 0, 0);
        chk("err_pulse", 32'(bus.err_double_free), 0);

        // Random traffic: sparse frees first to reach out-of-memory, then heavier
        for (int i = 0; i < 3000; i++) begin
            bit en, fe;
            en = 1'($urandom_range(0, 1));
            fe = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            step(en, fe, int'($urandom_range(0, 1023)));
        end

        // Reach a held grant, then reset asynchronously mid-cycle
        for (int i = 0; i < 200 && !(m_found && m_mode == M_GRANT); i++)
            step(i % 2 == 1, i % 4 == 0, int'($urandom_range(0, 1023)));
        chk("pre_rst_found", 32'(bus.adr_found), 1);
        bus.enable = 1'b0; bus.free_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("async_found", 32'(bus.adr_found), 0);
        chk("async_addr", 32'(bus.address), 0);
        chk("async_count", 32'(bus.free_count), 0);
        @(negedge clock);
        resetn = 1'b1;
        wait_ready("reinit");
        step(1, 0, 0);
        chk("reinit_addr", 32'(bus.address), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
